// File: rtl/weight_rom_stream_scheduler_pkg.sv
// Shared types and sizing for the weight ROM stream scheduler.
package weight_stream_pkg;
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int ROM_LATENCY  = 2;
    localparam int FIFO_DEPTH   = ROM_LATENCY + 2;
    localparam int CREDIT_WIDTH = $clog2(FIFO_DEPTH + 1);
endpackage

// File: rtl/weight_rom_stream_scheduler_if.sv
// Control, ROM and stream signals of the scheduler; master is the scheduler side.
interface weight_rom_stream_scheduler_if #(
    parameter int DATA_WIDTH   = 128,
    parameter int ADDR_WIDTH   = 11,
    parameter int REPEAT_WIDTH = 8
);
    logic                    start;
    logic [REPEAT_WIDTH-1:0] repeat_count;
    logic                    busy;
    logic                    done;
    logic [ADDR_WIDTH-1:0]   rom_addr;
    logic                    rom_ce;
    logic [DATA_WIDTH-1:0]   rom_q;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    data_out_valid;
    logic                    data_out_ready;

    modport master (
        input  start, repeat_count, rom_q, data_out_ready,
        output busy, done, rom_addr, rom_ce, data_out, data_out_valid
    );

    modport slave (
        output start, repeat_count, rom_q, data_out_ready,
        input  busy, done, rom_addr, rom_ce, data_out, data_out_valid
    );
endinterface

// File: rtl/weight_rom_stream_scheduler_fifo.sv
// Small synchronous FIFO holding returned ROM beats; head is read straight from storage.
module weight_stream_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/weight_rom_stream_scheduler.sv
// Credit-based scheduler streaming a 2-cycle-latency weight ROM repeat_count times per start.
module weight_rom_stream_scheduler
    import weight_stream_pkg::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int DEPTH        = 576,
    parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1,
    parameter int REPEAT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    weight_rom_stream_scheduler_if.master bus
);
    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [REPEAT_WIDTH-1:0] pass;
    logic [REPEAT_WIDTH-1:0] passes;
    logic [CREDIT_WIDTH-1:0] credits;
    logic [ROM_LATENCY-1:0]  vld_pipe;
    logic                    issue;
    logic                    pop;
    logic                    push;
    logic                    done;
    logic                    last_addr;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   fifo_head;

    assign last_addr = (addr == ADDR_WIDTH'(DEPTH - 1));
    assign pop       = !fifo_empty && bus.data_out_ready;
    assign push      = vld_pipe[ROM_LATENCY-1];

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                // A same-cycle pop frees a slot, keeping 1 beat/cycle at full credit.
                issue = (credits < CREDIT_WIDTH'(FIFO_DEPTH)) || pop;
                if (issue && last_addr && (pass == passes - REPEAT_WIDTH'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((vld_pipe == '0) && fifo_empty) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            pass     <= '0;
            passes   <= REPEAT_WIDTH'(1);
            credits  <= '0;
            vld_pipe <= '0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= {vld_pipe[ROM_LATENCY-2:0], issue};
            if (state == IDLE && bus.start) begin
                passes <= (bus.repeat_count == '0) ? REPEAT_WIDTH'(1) : bus.repeat_count;
                addr   <= '0;
                pass   <= '0;
            end else if (issue) begin
                if (last_addr) begin
                    addr <= '0;
                    pass <= pass + REPEAT_WIDTH'(1);
                end else begin
                    addr <= addr + ADDR_WIDTH'(1);
                end
            end
            if (issue && !pop) begin
                credits <= credits + CREDIT_WIDTH'(1);
            end else if (pop && !issue) begin
                credits <= credits - CREDIT_WIDTH'(1);
            end
            assert (credits <= CREDIT_WIDTH'(FIFO_DEPTH));
            assert (!(push && fifo_full && !pop));
        end
    end

    weight_stream_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_data(bus.rom_q),
        .pop    (pop),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign bus.busy           = (state != IDLE);
    assign bus.done           = done;
    assign bus.rom_addr       = addr;
    assign bus.rom_ce         = 1'b1;
    assign bus.data_out       = fifo_head;
    assign bus.data_out_valid = !fifo_empty;
endmodule

// File: tb/tb_weight_rom_stream_scheduler.sv
// Randomized and directed bench for weight_rom_stream_scheduler against an expected-beat queue model.
module tb_weight_rom_stream_scheduler;
    localparam int DW    = 128;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH) + 1;
    localparam int RW    = 8;
    localparam int MAXC  = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    weight_rom_stream_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REPEAT_WIDTH(RW)) bus ();

    weight_rom_stream_scheduler #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .REPEAT_WIDTH(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ROM model: word = address + 0x100, two registered stages of latency
    logic [DW-1:0] rom_s1;
    always @(posedge clk) begin
        rom_s1    <= DW'(bus.rom_addr) + DW'('h100);
        bus.rom_q <= rom_s1;
    end

    int tests = 0, fails = 0;
    int cyc, beats, issues, dones, first_valid_cyc, last_accept_cyc, done_cyc, max_out, mode;
    logic running;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] prev_addr;
    logic prev_valid, prev_acc;
    logic [DW-1:0] prev_data;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic rdy, acc;
        @(negedge clk);
        cyc++;
        bus.start = (mode == 3 && cyc == 5);
        if (mode == 3 && cyc == 5) bus.repeat_count = 7;
        if (bus.rom_addr !== prev_addr) begin
            chk("addr_order", DW'(bus.rom_addr), DW'((int'(prev_addr) + 1) % DEPTH));
            issues++;
        end
        prev_addr = bus.rom_addr;
        if (issues - beats > max_out) max_out = issues - beats;
        if (running) chk("busy_high", DW'(bus.busy), 1);
        if (bus.data_out_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
        if (prev_valid && !prev_acc) begin
            chk("valid_hold", DW'(bus.data_out_valid), 1);
            chk("data_hold", bus.data_out, prev_data);
        end
        case (mode)
            1: rdy = 1'($urandom_range(0, 1));
            2: rdy = !(first_valid_cyc != 0 && cyc < first_valid_cyc + 10);
            default: rdy = 1'b1;
        endcase
        bus.data_out_ready = rdy;
        if (mode == 2 && first_valid_cyc != 0 && cyc == first_valid_cyc + 9) begin
            chk("stall_addr", DW'(bus.rom_addr), 4);
            chk("stall_data", bus.data_out, DW'('h100));
            chk("stall_outstanding", DW'(issues - beats), 4);
        end
        acc = bus.data_out_valid && rdy;
        if (acc) begin
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else chk("beat", bus.data_out, exp_q.pop_front());
            beats++;
            last_accept_cyc = cyc;
        end
        if (bus.done) begin
            dones++;
            done_cyc = cyc;
        end
        prev_valid = bus.data_out_valid;
        prev_acc   = acc;
        prev_data  = bus.data_out;
    endtask

    task automatic run(input int rc, input int md);
        int passes;
        passes = (rc == 0) ? 1 : rc;
        exp_q.delete();
        for (int p = 0; p < passes; p++)
            for (int a = 0; a < DEPTH; a++)
                exp_q.push_back(DW'(a + 'h100));
        mode = md; beats = 0; issues = 0; dones = 0; first_valid_cyc = 0;
        done_cyc = 0; last_accept_cyc = 0; max_out = 0; prev_valid = 0; prev_acc = 0;
        @(negedge clk);
        prev_addr = bus.rom_addr;
        bus.start = 1'b1;
        bus.repeat_count = RW'(rc);
        bus.data_out_ready = 1'b1;
        cyc = 0;
        running = 1'b1;
        while (dones == 0 && cyc < MAXC) begin
            cycle();
            if (md == 4 && beats == 3) break;
        end
        running = 1'b0;
        if (md == 4) begin
            chk("rst_run_beats", DW'(beats), 3);
            chk("rst_run_no_done", DW'(dones), 0);
            return;
        end
        chk("done_seen", DW'(dones), 1);
        chk("all_beats", DW'(exp_q.size()), 0);
        chk("beat_count", DW'(beats), DW'(DEPTH * passes));
        chk("issue_count", DW'(issues), DW'(DEPTH * passes));
        chk("credits_le4", DW'(max_out <= 4), 1);
        chk("done_after_last", DW'(done_cyc), DW'(last_accept_cyc + 1));
        if (md == 0 || md == 3) begin
            chk("first_valid_cyc", DW'(first_valid_cyc), 4);
            chk("done_cyc", DW'(done_cyc), DW'(DEPTH * passes + 4));
        end
        cycle();
        chk("busy_low_after", DW'(bus.busy), 0);
        chk("done_pulse_1cyc", DW'(bus.done), 0);
        chk("valid_low_after", DW'(bus.data_out_valid), 0);
        chk("one_done", DW'(dones), 1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.repeat_count = '0;
        bus.data_out_ready = 1'b0;
        running = 1'b0;
        mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", DW'(bus.busy), 0);
        chk("rst_done", DW'(bus.done), 0);
        chk("rst_valid", DW'(bus.data_out_valid), 0);
        chk("rst_addr", DW'(bus.rom_addr), 0);
        chk("rst_ce", DW'(bus.rom_ce), 1);
        rst = 1'b0;

        run(1, 0);
        run(3, 0);
        run(1, 2);
        run(5, 1);
        run(0, 0);
        run(1, 3);
        run(1, 4);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", DW'(bus.data_out_valid), 0);
        chk("midrst_done", DW'(bus.done), 0);
        chk("midrst_busy", DW'(bus.busy), 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", DW'(bus.done), 0);
            chk("post_rst_no_valid", DW'(bus.data_out_valid), 0);
        end
        chk("post_rst_addr", DW'(bus.rom_addr), 0);
        run(1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
